// File: rtl/btb_update_ctrl_if.sv
// Handshake bundle between the EX-stage update source, this controller and the BTB write port.
// master = controller side, slave = EX stage / BTB side.
interface btb_update_ctrl_if #(
  parameter int unsigned INDEX_WIDTH = 6
);
  logic                   exValid;
  logic                   exBranch;
  logic                   exTaken;
  logic [31:0]            exPc;
  logic [31:0]            exTarget;
  logic                   exReady;
  logic                   btbWrEn;
  logic                   btbWrRdy;
  logic [INDEX_WIDTH-1:0] btbWrIdx;
  logic [31:0]            btbWrPc;
  logic [31:0]            btbWrTarget;
  logic                   btbWrBranch;
  logic                   btbWrTaken;
  logic                   btbWrInval;

  modport master (
    input  exValid, exBranch, exTaken, exPc, exTarget, btbWrRdy,
    output exReady, btbWrEn, btbWrIdx, btbWrPc, btbWrTarget,
           btbWrBranch, btbWrTaken, btbWrInval
  );

  modport slave (
    output exValid, exBranch, exTaken, exPc, exTarget, btbWrRdy,
    input  exReady, btbWrEn, btbWrIdx, btbWrPc, btbWrTarget,
           btbWrBranch, btbWrTaken, btbWrInval
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved branch updates in order and writes them to the BTB,
// invalidating every set after reset or a flush before predictions are enabled.
module btb_update_ctrl #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned INDEX_WIDTH = $clog2(BTB_ENTRIES),
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushReq,
  output logic              predEnable,
  output logic [7:0]        dropCount,
  btb_update_ctrl_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(BTB_ENTRIES - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] sweep_idx, sweep_idx_nxt;

  logic [31:0]      fifo_pc     [FIFO_DEPTH];
  logic [31:0]      fifo_target [FIFO_DEPTH];
  logic             fifo_branch [FIFO_DEPTH];
  logic             fifo_taken  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  logic [31:0]      head_pc;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head_pc = fifo_pc[rd_ptr];
  assign push    = bus.exValid && bus.exReady;
  assign pop     = (state == RUN) && bus.btbWrEn && bus.btbWrRdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    sweep_idx_nxt   = sweep_idx;
    predEnable      = 1'b0;
    bus.exReady     = 1'b0;
    bus.btbWrEn     = 1'b0;
    bus.btbWrInval  = 1'b0;
    bus.btbWrIdx    = '0;
    bus.btbWrPc     = '0;
    bus.btbWrTarget = '0;
    bus.btbWrBranch = 1'b0;
    bus.btbWrTaken  = 1'b0;
    unique case (state)
      SWEEP: begin
        bus.btbWrEn    = 1'b1;
        bus.btbWrInval = 1'b1;
        bus.btbWrIdx   = sweep_idx;
        // A flush restarts the sweep even if this cycle's write was accepted.
        if (flushReq) begin
          sweep_idx_nxt = '0;
        end else if (bus.btbWrRdy) begin
          if (sweep_idx == LAST_IDX) begin
            state_nxt     = RUN;
            sweep_idx_nxt = '0;
          end else begin
            sweep_idx_nxt = sweep_idx + INDEX_WIDTH'(1);
          end
        end
      end
      RUN: begin
        predEnable      = 1'b1;
        bus.exReady     = !full && !flushReq;
        bus.btbWrEn     = !empty;
        bus.btbWrIdx    = head_pc[INDEX_WIDTH+1:2];
        bus.btbWrPc     = head_pc;
        bus.btbWrTarget = fifo_target[rd_ptr];
        bus.btbWrBranch = fifo_branch[rd_ptr];
        bus.btbWrTaken  = fifo_taken[rd_ptr];
        if (flushReq) begin
          state_nxt     = SWEEP;
          sweep_idx_nxt = '0;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if ((state == RUN) && flushReq) begin
      // The head write of this cycle still completes at the BTB; everything queued is dropped.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]     <= bus.exPc;
      fifo_target[wr_ptr] <= bus.exTarget;
      fifo_branch[wr_ptr] <= bus.exBranch;
      fifo_taken[wr_ptr]  <= bus.exTaken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropCount <= '0;
    end else if (bus.exValid && !bus.exReady && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_btb_update_ctrl;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned IW      = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flushReq = 1'b0;
  logic       predEnable;
  logic [7:0] dropCount;

  btb_update_ctrl_if #(.INDEX_WIDTH(IW)) bus ();

  btb_update_ctrl #(.BTB_ENTRIES(ENTRIES), .INDEX_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flushReq(flushReq),
    .predEnable(predEnable), .dropCount(dropCount), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: update list, sweep position, run flag, drop counter.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        br;
    logic        tk;
  } ent_t;

  ent_t        q[$];
  bit          m_run = 1'b0;
  int unsigned m_sweep = 0;
  int unsigned m_drop = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_run = 1'b0;
      m_sweep = 0;
      m_drop = 0;
    end else begin
      bit rdy;
      bit has_head;
      ent_t e;
      cyc++;
      rdy = m_run && (q.size() < DEPTH) && !flushReq;
      has_head = m_run && (q.size() > 0);
      if (bus.exValid && !rdy && m_drop < 255) m_drop++;
      if (has_head && bus.btbWrRdy) void'(q.pop_front());
      if (bus.exValid && rdy) begin
        e.pc = bus.exPc; e.tgt = bus.exTarget; e.br = bus.exBranch; e.tk = bus.exTaken;
        q.push_back(e);
      end
      if (m_run) begin
        if (flushReq) begin q.delete(); m_run = 1'b0; m_sweep = 0; end
      end else if (flushReq) begin
        m_sweep = 0;
      end else if (bus.btbWrRdy) begin
        m_sweep++;
        if (m_sweep == ENTRIES) begin m_run = 1'b1; m_sweep = 0; end
      end
    end
  end

  // Compare process: every cycle, between clock edges.
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_en;
    exp_rdy = m_run && (q.size() < DEPTH) && !flushReq;
    exp_en  = !m_run || (q.size() > 0);
    check("exReady", 32'(bus.exReady), 32'(exp_rdy));
    check("predEnable", 32'(predEnable), 32'(m_run));
    check("dropCount", 32'(dropCount), m_drop);
    check("btbWrEn", 32'(bus.btbWrEn), 32'(exp_en));
    if (!m_run) begin
      check("sweep_inval", 32'(bus.btbWrInval), 32'd1);
      check("sweep_idx", 32'(bus.btbWrIdx), m_sweep);
      check("sweep_data", bus.btbWrPc | bus.btbWrTarget | 32'(bus.btbWrBranch) | 32'(bus.btbWrTaken), 32'd0);
    end else if (exp_en) begin
      check("run_inval", 32'(bus.btbWrInval), 32'd0);
      check("run_idx", 32'(bus.btbWrIdx), (q[0].pc >> 2) % ENTRIES);
      check("run_pc", bus.btbWrPc, q[0].pc);
      check("run_target", bus.btbWrTarget, q[0].tgt);
      check("run_flags", {30'd0, bus.btbWrBranch, bus.btbWrTaken}, {30'd0, q[0].br, q[0].tk});
    end
  end

  // Log of accepted (non-invalidate) BTB writes for ordering checks.
  typedef struct {
    int unsigned idx;
    int          c;
  } wr_t;
  wr_t wr_log[$];

  always @(negedge clk) begin
    wr_t w;
    if (rst && bus.btbWrEn && bus.btbWrRdy && !bus.btbWrInval) begin
      w.idx = bus.btbWrIdx;
      w.c = cyc;
      wr_log.push_back(w);
    end
  end

  task automatic push_update(input logic [31:0] pc);
    bus.exValid = 1'b1;
    bus.exPc = pc;
    bus.exTarget = pc + 32'h1000;
    bus.exBranch = 1'b1;
    bus.exTaken = pc[2];
    tick();
    bus.exValid = 1'b0;
  endtask

  task automatic wait_pred(input string name);
    int n;
    n = 0;
    while (!predEnable && n < 200) begin
      tick();
      n++;
    end
    check(name, n, 64);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_en"}, 32'(bus.btbWrEn), 32'd1);
    check({name, "_inval"}, 32'(bus.btbWrInval), 32'd1);
    check({name, "_idx"}, 32'(bus.btbWrIdx), 32'd0);
    check({name, "_pred"}, 32'(predEnable), 32'd0);
    check({name, "_ready"}, 32'(bus.exReady), 32'd0);
    check({name, "_drop"}, 32'(dropCount), 32'd0);
  endtask

  initial begin
    int c0;
    int n;
    bus.exValid = 1'b0; bus.exBranch = 1'b0; bus.exTaken = 1'b0;
    bus.exPc = '0; bus.exTarget = '0; bus.btbWrRdy = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    tick(); tick();
    rst = 1'b1;
    wait_pred("por_sweep_cycles");
    check("por_ready", 32'(bus.exReady), 32'd1);

    // Three back-to-back updates, BTB always ready.
    wr_log.delete();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      bus.exValid = 1'b1; bus.exPc = 32'h100 + 32'(4 * i); bus.exTarget = 32'h2000;
      bus.exBranch = 1'b1; bus.exTaken = 1'b1;
      tick();
    end
    bus.exValid = 1'b0;
    tick(); tick();
    check("order_count", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      check("order_idx", wr_log[i].idx, i);
      check("order_cycle", wr_log[i].c, c0 + 1 + i);
    end

    // Full queue with BTB stalled: four queued, two dropped, then drained in order.
    wr_log.delete();
    bus.btbWrRdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.exValid = 1'b1; bus.exPc = 32'h10 + 32'(4 * i);
      tick();
      if (i == 3) check("full_ready", 32'(bus.exReady), 32'd0);
    end
    bus.exValid = 1'b0;
    check("full_drop", 32'(dropCount), 32'd2);
    bus.btbWrRdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("drain_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("drain_idx", wr_log[i].idx, 4 + i);

    // Flush while three updates are queued.
    wr_log.delete();
    bus.btbWrRdy = 1'b0;
    for (int i = 0; i < 3; i++) push_update(32'h80 + 32'(4 * i));
    flushReq = 1'b1; bus.btbWrRdy = 1'b1;
    tick();
    flushReq = 1'b0;
    check("flush_idx", 32'(bus.btbWrIdx), 32'd0);
    check("flush_inval", 32'(bus.btbWrInval), 32'd1);
    wait_pred("flush_sweep_cycles");
    check("flush_writes", wr_log.size(), 1);
    if (wr_log.size() > 0) check("flush_head_idx", wr_log[0].idx, 32);

    // Flush in the middle of a sweep.
    flushReq = 1'b1; tick(); flushReq = 1'b0;
    n = 0;
    while (bus.btbWrIdx != 6'd30 && n < 100) begin tick(); n++; end
    check("msweep_at30", 32'(bus.btbWrIdx), 32'd30);
    flushReq = 1'b1; tick(); flushReq = 1'b0;
    check("msweep_restart", 32'(bus.btbWrIdx), 32'd0);
    wait_pred("msweep_cycles");

    // Drop counter saturation.
    bus.btbWrRdy = 1'b0;
    bus.exValid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    bus.exValid = 1'b0;
    check("drop_saturate", 32'(dropCount), 32'd255);
    flushReq = 1'b1; bus.btbWrRdy = 1'b1; tick(); flushReq = 1'b0;
    wait_pred("sat_sweep_cycles");

    // Reset with two updates queued.
    bus.btbWrRdy = 1'b0;
    push_update(32'h8);
    push_update(32'hC);
    rst = 1'b0;
    #1 check_reset_outputs("midrst");
    tick();
    rst = 1'b1;
    bus.btbWrRdy = 1'b1;
    wait_pred("midrst_sweep_cycles");
    check("midrst_empty", 32'(bus.btbWrEn), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.exValid  = ($urandom_range(0, 1) == 1);
      bus.exPc     = $urandom;
      bus.exTarget = $urandom;
      bus.exBranch = $urandom_range(0, 1);
      bus.exTaken  = $urandom_range(0, 1);
      bus.btbWrRdy = ($urandom_range(0, 9) < 7);
      flushReq     = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 2) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    flushReq = 1'b0;
    bus.exValid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 64, number of BTB sets swept and indexed.
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(BTB_ENTRIES), BTB index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, update-queue depth, power of 2, minimum 2.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port exValid, input, 1, EX-stage control-flow result valid this cycle.
REQ-007 SHALL have ports exBranch/exTaken, input, 1 each, intentional branch/jump flag and resolved direction.
REQ-008 SHALL have ports exPc/exTarget, input, 32 each, resolved instruction PC and target.
REQ-009 SHALL have port exReady, output, 1, queue can accept an update this cycle.
REQ-010 SHALL have port flushReq, input, 1, single-cycle request to invalidate the whole BTB.
REQ-011 SHALL have port btbWrEn, output, 1, BTB write request valid.
REQ-012 SHALL have port btbWrRdy, input, 1, BTB accepts the write this cycle.
REQ-013 SHALL have port btbWrIdx, output, INDEX_WIDTH, target set.
REQ-014 SHALL have ports btbWrPc/btbWrTarget, output, 32 each, update PC and target.
REQ-015 SHALL have ports btbWrBranch/btbWrTaken/btbWrInval, output, 1 each, update flags; Inval=1 means clear valid bit.
REQ-016 SHALL have port predEnable, output, 1, fetch may use BTB hits.
REQ-017 SHALL have port dropCount, output, 8, saturating count of updates lost.

Function
REQ-018 SHALL implement FSM states SWEEP and RUN only.
REQ-019 SHALL enqueue {exPc, exTarget, exBranch, exTaken} on a rising edge when exValid && exReady.
REQ-020 SHALL drive exReady = (state==RUN) && !full && !flushReq.
REQ-021 SHALL increment dropCount (saturating at 255) on each edge with exValid && !exReady.
REQ-022 SHALL in RUN drive btbWrEn = !empty, presenting the FIFO head combinationally, btbWrInval=0, btbWrIdx = head PC[INDEX_WIDTH+1:2].
REQ-023 SHALL pop the head on each edge with btbWrEn && btbWrRdy.
REQ-024 SHALL track occupancy 0..FIFO_DEPTH; simultaneous push and pop leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL preserve update order: BTB writes occur in exValid acceptance order.
REQ-026 SHALL in SWEEP drive btbWrEn=1, btbWrInval=1, btbWrIdx=sweepIdx, and other write data 0.
REQ-027 SHALL increment sweepIdx on each edge with btbWrRdy in SWEEP; after acceptance at index BTB_ENTRIES-1, go to RUN next cycle with sweepIdx=0.
REQ-028 SHALL hold predEnable=0 in SWEEP and 1 in RUN.
REQ-029 SHALL on flushReq in RUN: complete any write handshake of that cycle, discard all remaining FIFO entries (occupancy 0), enter SWEEP with sweepIdx=0 next cycle.
REQ-030 SHALL on flushReq in SWEEP restart sweepIdx at 0 next cycle, ignoring that cycle's btbWrRdy increment.
REQ-031 SHALL sweep in exactly BTB_ENTRIES cycles when btbWrRdy is held 1; each btbWrRdy=0 cycle adds one cycle.

Reset
REQ-032 SHALL on rst=0 immediately set state=SWEEP, sweepIdx=0, FIFO empty, dropCount=0.
REQ-033 SHALL during reset output btbWrEn=1, btbWrInval=1, btbWrIdx=0, predEnable=0, exReady=0.
REQ-034 SHALL begin the power-on sweep on the first rising edge after rst deasserts.
REQ-035 SHALL abort any sweep or queued update when reset asserts mid-operation and restart from REQ-032.

Verification
REQ-036 Power-on: release rst, btbWrRdy=1 -> indices 0..63 invalidated in 64 cycles, predEnable=1 on cycle 65, exReady=1.
REQ-037 Ordering: 3 back-to-back updates PC 0x100,0x104,0x108 with btbWrRdy=1 -> writes idx 0,1,2 in order, each one cycle after its push.
REQ-038 Full/drop: btbWrRdy=0, 6 updates -> 4 queued, exReady=0 after 4th, dropCount=2; btbWrRdy=1 drains 4 in order.
REQ-039 Flush mid-run: 3 queued, flushReq with btbWrRdy=1 -> head written, remaining 2 discarded, sweep starts at idx 0, predEnable=0 for 64 cycles.
REQ-040 Flush mid-sweep: flushReq at sweepIdx=30 -> next btbWrIdx=0, RUN reached 64 cycles later.
REQ-041 Reset mid-drain: rst low with 2 queued -> outputs per REQ-033 immediately, queue empty, dropCount=0.
